usb_buffer_arbiter: RTL and testbench

- Owns the single-ported USB data buffer. Each cycle it grants at most one of three requesters access to the buffer.
- Requesters: RX byte stores, TX byte fetches, and AHB-side byte stores and fetches.
- Sits between usb_rx, the TX encoder, the AHB slave interface and the data buffer.
- Also sequences flush and clear against in-flight requests, and enforces the full/empty rules.

---
 rtl/usb_pkg.sv | 16 +
 rtl/usb_req_slot.sv | 31 +++
 rtl/usb_buffer_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_usb_buffer_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared widths and the requester encoding used for grants and read-return tags
// across the USB buffer arbiter.
package usb_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int OCC_W  = 7;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_RX,
        REQ_TX,
        REQ_AHB
    } req_e;

endpackage

// File: rtl/usb_req_slot.sv
// One-entry pending request register. A new pulse refills the slot when it is empty
// or being taken this cycle; otherwise the new pulse is dropped and collide flags it.
module usb_req_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set,
    input  logic         take,
    input  logic [W-1:0] din,
    output logic         pending,
    output logic [W-1:0] dout,
    output logic         collide
);

    assign collide = set && pending && !take;

    // NOTE: state uses non-blocking assignments so all slots update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            dout    <= '0;
        end else if (!pending || take) begin
            pending <= set;
            if (set) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/usb_buffer_arbiter.sv
// Single-port USB data buffer arbiter: grants one of RX store, TX fetch or AHB access
// per cycle, sequences flush/clear and applies the buffer full/empty rules.
module usb_buffer_arbiter
    import usb_pkg::*;
#(
    parameter int AHB_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_store,
    input  logic [DATA_W-1:0] rx_wdata,
    output logic              rx_overrun,
    input  logic              tx_get,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              tx_rvalid,
    input  logic              ahb_store,
    input  logic              ahb_get,
    input  logic [DATA_W-1:0] ahb_wdata,
    output logic [DATA_W-1:0] ahb_rdata,
    output logic              ahb_rvalid,
    output logic              ahb_busy,
    output logic              ahb_err,
    input  logic              flush,
    input  logic              clear,
    input  logic [OCC_W-1:0]  buffer_occupancy,
    output logic              buf_write,
    output logic              buf_read,
    output logic [DATA_W-1:0] buf_wdata,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              buf_clear
);

    localparam int AGE_W = $clog2(AHB_MAX_WAIT + 1);

    logic              rx_pend, tx_pend, ahb_pend;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W:0]   ahb_slot_q;
    logic              ahb_is_write;
    logic [DATA_W-1:0] ahb_data;
    logic              rx_collide;
    logic [1:0]        tx_slot_unused;
    logic              ahb_collide_unused;

    logic              clr_q, clr_rx_q;
    logic [AGE_W-1:0]  age_q;
    req_e              grant, tag_q;

    logic has_room, has_data, tx_ready, ahb_first;
    logic rx_full, ahb_fail, ahb_drop, ahb_quick, ahb_fetch_empty;
    logic ahb_accept, ahb_reject;
    logic rx_take, tx_take, ahb_take;

    assign has_room  = buffer_occupancy < OCC_W'(DEPTH);
    assign has_data  = buffer_occupancy != '0;
    assign tx_ready  = tx_pend && has_data;
    assign ahb_first = age_q >= AGE_W'(AHB_MAX_WAIT);

    assign {ahb_is_write, ahb_data} = ahb_slot_q;

    // An AHB pulse is only captured into an idle AHB path and only if it is unambiguous.
    assign ahb_accept = (ahb_store ^ ahb_get) && !ahb_busy;
    assign ahb_reject = (ahb_store || ahb_get) && (ahb_busy || (ahb_store && ahb_get));

    // The clear cycle empties TX/AHB slots; RX survives a flush but not a clear.
    assign rx_take  = (grant == REQ_RX) || (clr_q && clr_rx_q);
    assign tx_take  = (grant == REQ_TX) || clr_q;
    assign ahb_take = (grant == REQ_AHB) || clr_q;

    usb_req_slot #(.W(DATA_W)) u_rx_slot (
        .clk     (clk),
        .rst     (rst),
        .set     (rx_store),
        .take    (rx_take),
        .din     (rx_wdata),
        .pending (rx_pend),
        .dout    (rx_data),
        .collide (rx_collide)
    );

    usb_req_slot #(.W(1)) u_tx_slot (
        .clk     (clk),
        .rst     (rst),
        .set     (tx_get),
        .take    (tx_take),
        .din     (1'b0),
        .pending (tx_pend),
        .dout    (tx_slot_unused[1:1]),
        .collide (tx_slot_unused[0])
    );

    usb_req_slot #(.W(DATA_W + 1)) u_ahb_slot (
        .clk     (clk),
        .rst     (rst),
        .set     (ahb_accept),
        .take    (ahb_take),
        .din     ({ahb_store, ahb_wdata}),
        .pending (ahb_pend),
        .dout    (ahb_slot_q),
        .collide (ahb_collide_unused)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        grant     = REQ_NONE;
        buf_write = 1'b0;
        buf_read  = 1'b0;
        buf_wdata = '0;
        rx_full   = 1'b0;
        ahb_fail  = 1'b0;
        if (!clr_q) begin
            // A pending RX always owns the cycle, even when the byte ends up dropped.
            if (rx_pend) begin
                grant = REQ_RX;
            end else if (ahb_pend && (ahb_first || !tx_ready)) begin
                grant = REQ_AHB;
            end else if (tx_ready) begin
                grant = REQ_TX;
            end
        end
        case (grant)
            REQ_RX: begin
                if (has_room) begin
                    buf_write = 1'b1;
                    buf_wdata = rx_data;
                end else begin
                    rx_full = 1'b1;
                end
            end
            REQ_TX: buf_read = 1'b1;
            REQ_AHB: begin
                if (ahb_is_write) begin
                    if (has_room) begin
                        buf_write = 1'b1;
                        buf_wdata = ahb_data;
                    end else begin
                        ahb_fail = 1'b1;
                    end
                end else if (has_data) begin
                    buf_read = 1'b1;
                end else begin
                    ahb_fail = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ahb_drop        = clr_q && ahb_pend;
    assign ahb_quick       = (grant == REQ_AHB) && !buf_read;
    assign ahb_fetch_empty = (grant == REQ_AHB) && !ahb_is_write && !has_data;
    assign buf_clear       = clr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q      <= 1'b0;
            clr_rx_q   <= 1'b0;
            age_q      <= '0;
            tag_q      <= REQ_NONE;
            rx_overrun <= 1'b0;
            tx_rvalid  <= 1'b0;
            tx_rdata   <= '0;
            ahb_rvalid <= 1'b0;
            ahb_err    <= 1'b0;
            ahb_rdata  <= '0;
            ahb_busy   <= 1'b0;
        end else begin
            clr_q    <= flush || clear;
            clr_rx_q <= clear;
            tag_q    <= buf_read ? grant : REQ_NONE;

            if (clr_q || (grant == REQ_AHB)) begin
                age_q <= '0;
            end else if (ahb_pend && !ahb_first) begin
                age_q <= age_q + AGE_W'(1);
            end

            rx_overrun <= rx_collide || rx_full;

            // Read data is taken the cycle after the grant, when the buffer presents it.
            tx_rvalid <= (tag_q == REQ_TX);
            if (tag_q == REQ_TX) begin
                tx_rdata <= buf_rdata;
            end

            ahb_rvalid <= ahb_quick || ahb_drop || (tag_q == REQ_AHB);
            ahb_err    <= ahb_fail || ahb_drop || ahb_reject;
            if (tag_q == REQ_AHB) begin
                ahb_rdata <= buf_rdata;
            end else if (ahb_fetch_empty) begin
                ahb_rdata <= '0;
            end

            if (ahb_accept) begin
                ahb_busy <= 1'b1;
            end else if (ahb_rvalid) begin
                ahb_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Self-checking bench: a FIFO buffer stand-in drives occupancy/read data, and a
// transaction-level model predicts every strobe and completion pulse cycle by cycle.
module tb_usb_buffer_arbiter;
    import usb_pkg::*;

    localparam int MAXW = 4;

    logic              clk, rst;
    logic              rx_store, tx_get, ahb_store, ahb_get, flush, clear;
    logic [DATA_W-1:0] rx_wdata, ahb_wdata, buf_rdata;
    logic [OCC_W-1:0]  buffer_occupancy;
    logic              rx_overrun, tx_rvalid, ahb_rvalid, ahb_busy, ahb_err;
    logic              buf_write, buf_read, buf_clear;
    logic [DATA_W-1:0] tx_rdata, ahb_rdata, buf_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    usb_buffer_arbiter #(.AHB_MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .rx_store(rx_store), .rx_wdata(rx_wdata), .rx_overrun(rx_overrun),
        .tx_get(tx_get), .tx_rdata(tx_rdata), .tx_rvalid(tx_rvalid),
        .ahb_store(ahb_store), .ahb_get(ahb_get), .ahb_wdata(ahb_wdata),
        .ahb_rdata(ahb_rdata), .ahb_rvalid(ahb_rvalid), .ahb_busy(ahb_busy), .ahb_err(ahb_err),
        .flush(flush), .clear(clear), .buffer_occupancy(buffer_occupancy),
        .buf_write(buf_write), .buf_read(buf_read), .buf_wdata(buf_wdata),
        .buf_rdata(buf_rdata), .buf_clear(buf_clear)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Buffer stand-in: FIFO of bytes.
    logic [7:0] mem[$];

    // Reference model: pending requests, AHB wait age, pending clear, and
    // future pulses kept in small rings indexed by cycle.
    bit         m_rx_p, m_tx_p, m_ahb_p, m_ahb_w, m_clr, m_clr_all, m_ahb_act;
    logic [7:0] m_rx_d, m_ahb_d;
    int         m_age, m_done;
    bit         s_rxov[4], s_txv[4], s_ahbv[4], s_ahbe[4], s_ahbdv[4];
    logic [7:0] s_txd[4], s_ahbd[4];

    task automatic model_reset();
        m_rx_p = 0; m_tx_p = 0; m_ahb_p = 0; m_ahb_w = 0; m_clr = 0; m_clr_all = 0;
        m_ahb_act = 0; m_rx_d = 0; m_ahb_d = 0; m_age = 0; m_done = -1;
        for (int i = 0; i < 4; i++) begin
            s_rxov[i] = 0; s_txv[i] = 0; s_ahbv[i] = 0; s_ahbe[i] = 0; s_ahbdv[i] = 0;
            s_txd[i] = 0; s_ahbd[i] = 0;
        end
    endtask

    task automatic ahb_finish(input int at, input bit err, input bit dv, input logic [7:0] d);
        s_ahbv[at % 4] = 1;
        if (err) s_ahbe[at % 4] = 1;
        if (dv) begin
            s_ahbdv[at % 4] = 1;
            s_ahbd[at % 4]  = d;
        end
        m_done = at;
    endtask

    task automatic step(input bit rs, input logic [7:0] rd, input bit tg,
                        input bit st, input bit gt, input logic [7:0] ad,
                        input bit fl, input bit cl);
        int         occ, k;
        bit         e_w, e_r, e_clr, e_busy, granted_ahb, tx_ok;
        logic [7:0] e_wd;
        bit         w_s, r_s, c_s;
        logic [7:0] wd_s;
        rx_store = rs; rx_wdata = rd; tx_get = tg;
        ahb_store = st; ahb_get = gt; ahb_wdata = ad; flush = fl; clear = cl;
        #4;
        occ = mem.size(); k = cyc % 4;
        e_w = 0; e_r = 0; e_clr = 0; e_wd = 0; granted_ahb = 0;
        e_busy = m_ahb_act && (m_done < 0 || cyc <= m_done);
        tx_ok = m_tx_p && occ > 0;
        if (m_clr) begin
            e_clr = 1;
            m_tx_p = 0;
            if (m_ahb_p) ahb_finish(cyc + 1, 1, 0, 0);
            if (m_clr_all) m_rx_p = 0;
            m_ahb_p = 0;
            m_age = 0;
        end else if (m_rx_p) begin
            if (occ < DEPTH) begin e_w = 1; e_wd = m_rx_d; end
            else s_rxov[(cyc + 1) % 4] = 1;
            m_rx_p = 0;
        end else if (m_ahb_p && (m_age >= MAXW || !tx_ok)) begin
            if (m_ahb_w) begin
                if (occ < DEPTH) begin e_w = 1; e_wd = m_ahb_d; ahb_finish(cyc + 1, 0, 0, 0); end
                else ahb_finish(cyc + 1, 1, 0, 0);
            end else if (occ > 0) begin
                e_r = 1; ahb_finish(cyc + 2, 0, 1, mem[0]);
            end else begin
                ahb_finish(cyc + 1, 1, 1, 8'h00);
            end
            m_ahb_p = 0; granted_ahb = 1; m_age = 0;
        end else if (tx_ok) begin
            e_r = 1;
            s_txv[(cyc + 2) % 4] = 1;
            s_txd[(cyc + 2) % 4] = mem[0];
            m_tx_p = 0;
        end
        if (m_ahb_p && !granted_ahb) m_age = (m_age < MAXW) ? m_age + 1 : MAXW;

        check("buf_clear", buf_clear, e_clr);
        check("buf_write", buf_write, e_w);
        if (e_w) check("buf_wdata", buf_wdata, e_wd);
        check("buf_read", buf_read, e_r);
        check("rx_overrun", rx_overrun, s_rxov[k]);
        check("tx_rvalid", tx_rvalid, s_txv[k]);
        if (s_txv[k]) check("tx_rdata", tx_rdata, s_txd[k]);
        check("ahb_rvalid", ahb_rvalid, s_ahbv[k]);
        check("ahb_err", ahb_err, s_ahbe[k]);
        if (s_ahbdv[k]) check("ahb_rdata", ahb_rdata, s_ahbd[k]);
        check("ahb_busy", ahb_busy, e_busy);
        s_rxov[k] = 0; s_txv[k] = 0; s_ahbv[k] = 0; s_ahbe[k] = 0; s_ahbdv[k] = 0;
        if (m_ahb_act && m_done == cyc) m_ahb_act = 0;

        if (rs) begin
            if (m_rx_p) s_rxov[(cyc + 1) % 4] = 1;
            else begin m_rx_p = 1; m_rx_d = rd; end
        end
        if (tg) m_tx_p = 1;
        if (st || gt) begin
            if (e_busy || (st && gt)) s_ahbe[(cyc + 1) % 4] = 1;
            else begin
                m_ahb_p = 1; m_ahb_w = st; m_ahb_d = ad; m_ahb_act = 1; m_done = -1;
            end
        end
        m_clr = fl || cl;
        m_clr_all = cl;

        w_s = buf_write; wd_s = buf_wdata; r_s = buf_read; c_s = buf_clear;
        @(posedge clk);
        #1;
        if (c_s) mem.delete();
        if (w_s) mem.push_back(wd_s);
        if (r_s && mem.size() > 0) buf_rdata = mem.pop_front();
        else buf_rdata = 8'($urandom);
        buffer_occupancy = OCC_W'(mem.size());
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic preload(input int n);
        mem.delete();
        repeat (n) mem.push_back(8'($urandom));
        buffer_occupancy = OCC_W'(n);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_rx_overrun"}, rx_overrun, 0);
        check({pfx, "_tx_rvalid"}, tx_rvalid, 0);
        check({pfx, "_tx_rdata"}, tx_rdata, 0);
        check({pfx, "_ahb_rvalid"}, ahb_rvalid, 0);
        check({pfx, "_ahb_rdata"}, ahb_rdata, 0);
        check({pfx, "_ahb_busy"}, ahb_busy, 0);
        check({pfx, "_ahb_err"}, ahb_err, 0);
        check({pfx, "_buf_write"}, buf_write, 0);
        check({pfx, "_buf_read"}, buf_read, 0);
        check({pfx, "_buf_wdata"}, buf_wdata, 0);
        check({pfx, "_buf_clear"}, buf_clear, 0);
    endtask

    task automatic mid_reset();
        rx_store = 0; tx_get = 0; ahb_store = 0; ahb_get = 0; flush = 0; clear = 0;
        #2 rst = 1;
        #1 check_all_zero("arst");
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        buf_rdata = 8'($urandom);
        cyc++;
    endtask

    task automatic random_run(input int n, input int p_rx, input int p_tx, input int p_ahb, input int p_clr);
        repeat (n) begin
            bit rs, tg, st, gt, fl, cl;
            int a;
            rs = $urandom_range(99) < p_rx;
            tg = $urandom_range(99) < p_tx;
            a  = $urandom_range(99);
            st = a < p_ahb;
            gt = (a >= p_ahb) && (a < 2 * p_ahb);
            if (a == 99) begin st = 1; gt = 1; end
            fl = $urandom_range(99) < p_clr;
            cl = $urandom_range(199) < p_clr;
            step(rs, 8'($urandom), tg, st, gt, 8'($urandom), fl, cl);
        end
    endtask

    initial begin
        rst = 1;
        rx_store = 0; tx_get = 0; ahb_store = 0; ahb_get = 0; flush = 0; clear = 0;
        rx_wdata = 0; ahb_wdata = 0; buf_rdata = 0; buffer_occupancy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        rst = 0;
        @(posedge clk);
        #1;

        // RX store into empty buffer, then TX fetch of that byte.
        step(1, 8'hA5, 0, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(4);

        // Three-way contention at occupancy 3.
        preload(3);
        step(1, 8'h3C, 1, 0, 1, 0, 0, 0);
        idle(6);

        // Continuous TX traffic with an AHB fetch waiting for promotion.
        preload(12);
        for (int i = 0; i < 14; i++) step(i == 3, 8'h77, 1, 0, i == 1, 0, 0, 0);
        idle(6);

        // Full and empty boundaries.
        preload(DEPTH);
        step(1, 8'h11, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 8'h22, 0, 0);
        idle(4);
        preload(0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(4);
        step(1, 8'h5A, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Clear against a pending AHB store; flush/clear against a pending RX.
        preload(5);
        step(1, 8'h01, 0, 1, 0, 8'hEE, 0, 0);
        step(1, 8'h02, 0, 0, 0, 0, 0, 1);
        idle(4);
        step(1, 8'h44, 0, 0, 0, 0, 1, 0);
        idle(4);
        step(1, 8'h55, 0, 0, 0, 0, 0, 1);
        idle(4);

        // Overruns: repeated RX while pending, AHB while busy, AHB store+get together.
        preload(10);
        step(1, 8'h66, 0, 0, 0, 0, 1, 0);
        step(1, 8'h67, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 8'h99, 0, 0);
        idle(4);
        step(0, 0, 0, 1, 1, 8'h12, 0, 0);
        idle(4);

        // Randomized traffic at mid, near-full and near-empty occupancy.
        preload(20);
        random_run(400, 30, 30, 15, 4);
        idle(6);
        preload(60);
        random_run(200, 60, 5, 20, 1);
        idle(6);
        preload(2);
        random_run(200, 5, 50, 20, 1);
        idle(6);
        preload(30);
        random_run(60, 40, 40, 20, 2);
        mid_reset();
        random_run(120, 40, 40, 20, 2);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
